// File: rtl/timer_core.sv
// Programmable up-counter with one-shot and auto-reload modes.
// Reports run status and the live count, and raises a one-cycle expiry pulse.
module timer_core #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rf_trig_start,
    input  logic             rf_trig_halt,
    input  logic             rf_mode,
    input  logic [CNT_W-1:0] rf_termcount,
    output logic             ro_status,
    output logic [CNT_W-1:0] ro_currcount,
    output logic             timer_irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] term_q,  term_d;
    logic             mode_q,  mode_d;
    logic             irq_q,   irq_d;
    logic             status_q, status_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            term_q   <= '0;
            mode_q   <= 1'b0;
            irq_q    <= 1'b0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            term_q   <= term_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
            status_q <= status_d;
        end
    end

    // Halt outranks start, and both outrank the terminal match, so a match on
    // the same edge as either trigger never produces an irq.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        mode_d  = mode_q;
        irq_d   = 1'b0;

        if (rf_trig_halt) begin
            if (state_q == RUN) begin
                state_d = IDLE;
            end
        end else if (rf_trig_start) begin
            state_d = RUN;
            count_d = '0;
            term_d  = rf_termcount;
            mode_d  = rf_mode;
        end else if (state_q == RUN) begin
            if (count_q == term_q) begin
                irq_d = 1'b1;
                if (mode_q) begin
                    count_d = '0;
                end else begin
                    state_d = EXPIRED;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        status_d = (state_d == RUN);
    end

    assign ro_status    = status_q;
    assign ro_currcount = count_q;
    assign timer_irq    = irq_q;

endmodule
